// File: rtl/compare_persistence_filter.sv
// compare_persistence_filter: persistence-filtered a>b / a<b relation with crossing pulses and saturating count
module compare_persistence_filter #(
  parameter int PERSIST = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             a_less_b,
  input  logic             a_equal_b,
  input  logic             a_greater_b,
  input  logic             clr_count,
  output logic             state_valid,
  output logic             state_high,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] cross_count,
  output logic             flag_err
);
  localparam int RW = $clog2(PERSIST + 1);
  typedef enum logic [1:0] {UNKNOWN, LOW, HIGH} state_t;
  state_t state;
  logic [RW-1:0] run, run_nx;
  logic run_dir, dir_nx, gt, lt, eq, bad, hit, to_low;
  assign gt = in_valid & a_greater_b & ~a_less_b & ~a_equal_b;
  assign lt = in_valid & a_less_b & ~a_greater_b & ~a_equal_b;
  assign eq = in_valid & a_equal_b & ~a_less_b & ~a_greater_b;
  assign bad = in_valid & ~(gt | lt | eq);
  // EQ, BAD and idle cycles fall through every branch, so the run holds
  always_comb begin
    dir_nx = run_dir;
    run_nx = run;
    if (state == UNKNOWN) begin
      if (gt | lt) begin
        dir_nx = gt;
        run_nx = (gt == run_dir) ? run + RW'(1) : RW'(1);
      end
    end else if (state == HIGH ? lt : gt) run_nx = run + RW'(1);
    else if (state == HIGH ? gt : lt) run_nx = '0;
  end
  assign hit = run_nx == RW'(PERSIST);
  assign to_low = state == HIGH || (state == UNKNOWN && !dir_nx);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= UNKNOWN;
      run <= '0;
      run_dir <= 1'b0;
      state_valid <= 1'b0;
      state_high <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      cross_count <= '0;
      flag_err <= 1'b0;
    end else begin
      run <= hit ? '0 : run_nx;
      run_dir <= dir_nx;
      rise_pulse <= hit && state == LOW;
      fall_pulse <= hit && state == HIGH;
      if (hit) begin
        state <= to_low ? LOW : HIGH;
        state_high <= !to_low;
        state_valid <= 1'b1;
      end
      cross_count <= clr_count ? '0 :
                     (hit && state != UNKNOWN && cross_count != '1) ? cross_count + CNT_W'(1) : cross_count;
      flag_err <= !clr_count && (flag_err || bad);
    end
  end
endmodule

// File: tb/tb_compare_persistence_filter.sv
// tb_compare_persistence_filter: two DUT configurations driven in lockstep, scoreboarded against a sample-history model
module tb_compare_persistence_filter;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic a_less_b = 1'b0, a_equal_b = 1'b0, a_greater_b = 1'b0, clr_count = 1'b0;
  logic sv0, sh0, rp0, fp0, fe0, sv1, sh1, rp1, fp1, fe1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  typedef struct packed {logic sv, sh, rp, fp, fe; logic [7:0] cnt;} obs_t;
  obs_t obs0, obs1, sb[$], m[2];
  int st[2];
  int hist[2][$];
  int plen[2] = '{4, 1};
  int cmax[2] = '{255, 3};
  int vectors = 0, miscompares = 0;
  string phase = "reset";
  always #5 clk = ~clk;
  compare_persistence_filter #(.PERSIST(4), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a_less_b(a_less_b), .a_equal_b(a_equal_b),
    .a_greater_b(a_greater_b), .clr_count(clr_count), .state_valid(sv0), .state_high(sh0),
    .rise_pulse(rp0), .fall_pulse(fp0), .cross_count(cnt0), .flag_err(fe0));
  compare_persistence_filter #(.PERSIST(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a_less_b(a_less_b), .a_equal_b(a_equal_b),
    .a_greater_b(a_greater_b), .clr_count(clr_count), .state_valid(sv1), .state_high(sh1),
    .rise_pulse(rp1), .fall_pulse(fp1), .cross_count(cnt1), .flag_err(fe1));
  assign obs0 = {sv0, sh0, rp0, fp0, fe0, cnt0};
  assign obs1 = {sv1, sh1, rp1, fp1, fe1, 6'b0, cnt1};
  task automatic check(input string name, input obs_t got, input obs_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s [%s]: got valid=%b high=%b rise=%b fall=%b err=%b cnt=%0d, required valid=%b high=%b rise=%b fall=%b err=%b cnt=%0d",
               name, phase, got.sv, got.sh, got.rp, got.fp, got.fe, got.cnt,
               exp.sv, exp.sh, exp.rp, exp.fp, exp.fe, exp.cnt);
    end
  endtask
  // The filtered state changes once the last PERSIST strict samples since the previous change all agree
  task automatic model_step(input int k, input logic rst, input logic v, l, e, g, c);
    int want, sum;
    bit all, trans;
    if (!rst) begin
      st[k] = 0;
      m[k] = '0;
      hist[k].delete();
      return;
    end
    m[k].rp = 0;
    m[k].fp = 0;
    trans = 0;
    sum = int'(l) + int'(e) + int'(g);
    if (v && sum != 1) m[k].fe = 1;
    if (v && sum == 1 && !e) begin
      hist[k].push_back(int'(g));
      if (hist[k].size() > plen[k]) void'(hist[k].pop_front());
      if (hist[k].size() == plen[k]) begin
        want = st[k] == 0 ? hist[k][0] : (st[k] == 2 ? 0 : 1);
        all = 1;
        for (int i = 0; i < hist[k].size(); i++) if (hist[k][i] != want) all = 0;
        if (all) begin
          if (st[k] != 0) begin
            trans = 1;
            if (st[k] == 2) m[k].fp = 1; else m[k].rp = 1;
          end
          st[k] = want != 0 ? 2 : 1;
          m[k].sv = 1;
          hist[k].delete();
        end
      end
    end
    m[k].sh = st[k] == 2;
    if (c) begin
      m[k].cnt = 0;
      m[k].fe = 0;
    end else if (trans && m[k].cnt < cmax[k]) m[k].cnt = m[k].cnt + 8'd1;
  endtask
  task automatic cyc(input logic v, l, e, g, c);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = v;
    a_less_b = l;
    a_equal_b = e;
    a_greater_b = g;
    clr_count = c;
    for (int k = 0; k < 2; k++) model_step(k, 1'b1, v, l, e, g, c);
    sb.push_back(m[0]);
    sb.push_back(m[1]);
  endtask
  task automatic gt_s(); cyc(1, 0, 0, 1, 0); endtask
  task automatic lt_s(); cyc(1, 1, 0, 0, 0); endtask
  task automatic rst_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    {in_valid, a_less_b, a_equal_b, a_greater_b, clr_count} = '0;
    #1;
    check("async_rst_dut0", obs0, '0);
    check("async_rst_dut1", obs1, '0);
    for (int k = 0; k < 2; k++) model_step(k, 1'b0, 0, 0, 0, 0, 0);
    sb.push_back(m[0]);
    sb.push_back(m[1]);
  endtask
  always begin
    @(posedge clk);
    #1;
    if (sb.size() >= 2) begin
      check("dut0", obs0, sb.pop_front());
      check("dut1", obs1, sb.pop_front());
    end
  end
  initial begin
    int dir, r, v, sel;
    rst_pulse();
    cyc(0, 0, 0, 0, 0);
    phase = "establish";
    repeat (4) gt_s();
    phase = "glitch";
    repeat (3) lt_s();
    gt_s();
    repeat (4) lt_s();
    cyc(0, 0, 0, 0, 0);
    phase = "eq_idle";
    gt_s(); gt_s(); cyc(1, 0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    gt_s(); gt_s();
    cyc(0, 0, 0, 0, 0);
    phase = "err_flag";
    cyc(1, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 1, 1, 1);
    phase = "saturate";
    repeat (3) begin gt_s(); lt_s(); end
    cyc(1, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0);
    phase = "reset_mid_run";
    repeat (4) lt_s();
    repeat (3) gt_s();
    rst_pulse();
    cyc(0, 0, 0, 0, 0);
    repeat (5) gt_s();
    phase = "random";
    dir = 1;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2) rst_pulse();
      else begin
        if ($urandom_range(0, 99) < 12) dir = 1 - dir;
        v = $urandom_range(0, 9) < 8;
        sel = $urandom_range(0, 99);
        if (sel < 70) cyc(v[0], dir == 0, 0, dir == 1, $urandom_range(0, 24) == 0);
        else if (sel < 82) cyc(v[0], dir == 1, 0, dir == 0, 0);
        else if (sel < 94) cyc(v[0], 0, 1, 0, 0);
        else cyc(v[0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, $urandom_range(0, 3) == 0);
      end
    end
    phase = "drain";
    repeat (3) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending entries, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/compare_persistence_filter.md
Name: compare_persistence_filter

Overview:
- Downstream consumer of the magnitude comparator's three relation flags (a_less_b, a_equal_b, a_greater_b).
- Applies persistence (glitch) filtering: the filtered relation changes only after PERSIST consecutive valid samples of the opposite strict relation.
- Emits single-cycle rise/fall event pulses and keeps a saturating crossing counter for threshold-monitor logic.

Parameters:
- PERSIST, 4, consecutive qualifying samples required to change state; legal range 1..255.
- CNT_W, 8, width of crossing counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  flags below are a valid sample this cycle.
- a_less_b  input  1  comparator flag.
- a_equal_b  input  1  comparator flag.
- a_greater_b  input  1  comparator flag.
- clr_count  input  1  synchronous clear of cross_count and flag_err.
- state_valid  output  1  filtered state established (left UNKNOWN).
- state_high  output  1  filtered relation: 1 = HIGH (a>b persisted), 0 = LOW or UNKNOWN.
- rise_pulse  output  1  one-cycle pulse on LOW->HIGH.
- fall_pulse  output  1  one-cycle pulse on HIGH->LOW.
- cross_count  output  CNT_W  number of LOW<->HIGH transitions, saturating.
- flag_err  output  1  sticky: a valid sample arrived with flags not exactly one-hot.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low on rst_n. While rst_n=0 all outputs are 0, FSM=UNKNOWN, run counter=0, run_dir=0. Deassertion takes effect on the next clk edge.
- Sample classes (in_valid=1 only):
  - GT = exactly a_greater_b.
  - LT = exactly a_less_b.
  - EQ = exactly a_equal_b.
  - BAD = any non-one-hot combination.
- in_valid=0: no state change, run counter holds, pulses 0.
- BAD sample: flag_err<=1 (sticky). Otherwise ignored; the run counter holds.
- EQ sample: neutral. The run counter holds, neither advancing nor resetting.
- Internal run counter: width ceil(log2(PERSIST+1)), plus run_dir (1=toward HIGH).
- FSM states: UNKNOWN, LOW, HIGH.
  - UNKNOWN:
    - GT with run_dir=1: run+1. GT otherwise: run=1, run_dir=1.
    - LT mirrors GT with run_dir=0.
    - When run reaches PERSIST: go to HIGH (GT) or LOW (LT), run=0, state_valid<=1. No pulse, no count.
  - HIGH:
    - LT: run+1. GT: run=0.
    - When run reaches PERSIST: go to LOW, fall_pulse=1 for one cycle, cross_count+1, run=0.
  - LOW: mirror of HIGH (GT advances, LT clears, rise_pulse on exit).
- Latency: the edge that samples the PERSIST-th qualifying sample updates state_high, state_valid, the pulse and cross_count. They are visible in the following cycle (1-cycle registered latency).
- PERSIST=1: every single opposite strict sample toggles the state.
- cross_count saturates at 2^CNT_W-1. A further transition still pulses but does not wrap.
- clr_count=1:
  - cross_count<=0 and flag_err<=0.
  - Priority over a same-cycle increment: the result is 0.
  - A same-cycle BAD sample is also cleared; clear wins.
  - The FSM and pulses are unaffected.
- Reset mid-run: partial run progress is discarded and the FSM returns to UNKNOWN.
- Pulses are never asserted in the same cycle as each other. At most one transition occurs per cycle.
- state_high=1 only in HIGH. state_valid stays 1 until reset.

Test Plan:
- Reset/establish: assert rst_n=0, release, drive 4 valid GT samples. Before the 4th edge, all outputs are 0. After it: state_valid=1, state_high=1, no pulse, cross_count=0.
- Filter glitch: in HIGH, drive LT,LT,LT,GT,LT,LT,LT. Required: no transition and state_high stays 1. Then one more LT: fall_pulse=1 for exactly one cycle, state_high=0, cross_count=1.
- EQ/invalid neutrality: in LOW, drive GT,GT,EQ,(in_valid=0 x3),GT,GT. Required: rise_pulse on the 4th GT only, cross_count increments by 1.
- Error flag: drive in_valid=1 with a_less_b=1 and a_greater_b=1. Required: flag_err=1 and run/state unchanged. Then clr_count=1: flag_err=0 and cross_count=0 next cycle.
- Saturation/clear priority (CNT_W=2, PERSIST=1): alternate GT/LT for 6 samples. Required: cross_count stops at 3 and pulses still occur. Then assert clr_count in the same cycle as a crossing: count=0, pulse still asserted.
- Async reset mid-run: in LOW after 3 GT samples, pulse rst_n low between edges. Required: outputs 0 immediately. After release, 4 fresh samples are needed to leave UNKNOWN.
